// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer, program counter and return-address stack for the 8-bit core.
// Latency: 2 cycles per 1-byte instruction, 3 per 2-byte instruction, plus 1 per ack wait cycle.
// Backpressure: imem_req and imem_addr are held until imem_ack is seen; optional trap build via PC_SEQ_STACK_TRAP_EN.
module pc_sequencer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [7:0]            imem_rdata,
  output logic [7:0]            ir,
  output logic [7:0]            arg,
  input  logic                  has_arg,
  input  logic                  jmp_en,
  input  logic                  is_ret,
  input  logic [1:0]            stack_control,
  input  logic                  soft_rst,
  output logic [1:0]            stack_flags,
  output logic                  exec_en,
  output logic                  stack_err,
  output logic [ADDR_WIDTH-1:0] pc
);

  localparam int          IDX_W = $clog2(STACK_DEPTH);
  localparam int          SP_W  = IDX_W + 1;
  localparam logic [7:0]  NOP   = 8'h11;

`ifdef PC_SEQ_STACK_TRAP_EN
  typedef enum logic [1:0] {S_FETCH, S_ARG, S_EXEC, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_ARG, S_EXEC} state_t;
`endif

  state_t                state;
  logic [SP_W-1:0]       sp;
  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic                  st_full;
  logic                  st_empty;
  logic [ADDR_WIDTH-1:0] arg_addr;
  logic [ADDR_WIDTH-1:0] stack_top;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic [SP_W-1:0]       sp_nxt;
  logic                  push_en;
  logic                  err_evt;
  logic                  fire;

  assign imem_addr = pc;
  assign st_full   = (sp == SP_W'(STACK_DEPTH));
  assign st_empty  = (sp == '0);
  assign arg_addr  = ADDR_WIDTH'(arg);
  assign stack_top = stack_mem[sp[IDX_W-1:0] - IDX_W'(1)];
  assign fire      = imem_req && imem_ack;

  // EXEC-cycle PC/stack resolution in decoder priority order.
  always_comb begin
    pc_nxt  = pc;
    sp_nxt  = sp;
    push_en = 1'b0;
    err_evt = 1'b0;
    if (soft_rst) begin
      pc_nxt = '0;
      sp_nxt = '0;
    end else if (stack_control == 2'b11) begin
      err_evt = 1'b1;
    end else if (stack_control == 2'b10 && jmp_en) begin
      if (st_full) begin
        err_evt = 1'b1;
      end else begin
        push_en = 1'b1;
        sp_nxt  = sp + SP_W'(1);
        pc_nxt  = arg_addr;
      end
    end else if (stack_control == 2'b01 && jmp_en) begin
      if (st_empty) begin
        err_evt = 1'b1;
      end else begin
        pc_nxt = stack_top;
        sp_nxt = sp - SP_W'(1);
      end
    end else if (is_ret && jmp_en && st_empty) begin
      err_evt = 1'b1;
    end else if (jmp_en) begin
      pc_nxt = arg_addr;
    end
  end

  // Return-address storage; only the stack pointer needs a reset value.
  always_ff @(posedge clk) begin
    if (state == S_EXEC && push_en) begin
      stack_mem[sp[IDX_W-1:0]] <= pc;
    end
  end

  // Sequencer FSM with registered request, strobe and flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      pc          <= '0;
      ir          <= NOP;
      arg         <= '0;
      imem_req    <= 1'b0;
      exec_en     <= 1'b0;
      sp          <= '0;
      stack_flags <= 2'b01;
      stack_err   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (fire) begin
            ir <= imem_rdata;
            pc <= pc + ADDR_WIDTH'(1);
            if (has_arg) begin
              state <= S_ARG;
            end else begin
              state    <= S_EXEC;
              imem_req <= 1'b0;
              exec_en  <= 1'b1;
            end
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_ARG: begin
          if (fire) begin
            arg      <= imem_rdata;
            pc       <= pc + ADDR_WIDTH'(1);
            state    <= S_EXEC;
            imem_req <= 1'b0;
            exec_en  <= 1'b1;
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_EXEC: begin
          exec_en     <= 1'b0;
          pc          <= pc_nxt;
          sp          <= sp_nxt;
          stack_flags <= {sp_nxt == SP_W'(STACK_DEPTH), sp_nxt == '0};
          if (err_evt) stack_err <= 1'b1;
          if (soft_rst) ir <= NOP;
`ifdef PC_SEQ_STACK_TRAP_EN
          if (err_evt) begin
            state    <= S_HALT;
            imem_req <= 1'b0;
          end else begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
`else
          state    <= S_FETCH;
          imem_req <= 1'b1;
`endif
        end
`ifdef PC_SEQ_STACK_TRAP_EN
        S_HALT: begin
          imem_req <= 1'b0;
          exec_en  <= 1'b0;
        end
`endif
        default: begin
          state    <= S_FETCH;
          imem_req <= 1'b0;
          exec_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a small opcode decoder and an imem responder.
// Latency: n/a (testbench).
// Backpressure: responder inserts ack_dly wait cycles per fetched byte.
module tb_pc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic [7:0] ir;
  logic [7:0] arg;
  logic       has_arg;
  logic       jmp_en;
  logic       is_ret;
  logic [1:0] stack_control;
  logic       soft_rst;
  logic [1:0] stack_flags;
  logic       exec_en;
  logic       stack_err;
  logic [7:0] pc;

  logic [7:0] imem [256];
  int         ack_dly;
  int         wcnt;
  int         cyc;
  int         exec_cnt;
  int         exec_cyc [$];
  logic [7:0] fetch_log [$];
  int         errors;
  int         checks;

  pc_sequencer #(.ADDR_WIDTH(8), .STACK_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .arg(arg), .has_arg(has_arg), .jmp_en(jmp_en), .is_ret(is_ret),
    .stack_control(stack_control), .soft_rst(soft_rst), .stack_flags(stack_flags),
    .exec_en(exec_en), .stack_err(stack_err), .pc(pc)
  );

  // Opcodes: 40 JMP a, 50 CLL a, 60 RET, 33 bad stack op, 7F illegal, others 1-byte.
  assign has_arg = (imem_rdata == 8'h40) || (imem_rdata == 8'h50);

  // Decoder model driven from the current opcode register.
  always_comb begin
    jmp_en        = (ir == 8'h40) || (ir == 8'h50) || (ir == 8'h60);
    is_ret        = (ir == 8'h60);
    soft_rst      = (ir == 8'h7F);
    stack_control = 2'b00;
    if (ir == 8'h50) stack_control = 2'b10;
    if (ir == 8'h60) stack_control = 2'b01;
    if (ir == 8'h33) stack_control = 2'b11;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: acks after ack_dly wait cycles, updated 2 time units after the edge.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 8'h11;
    wcnt       = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && imem_req) begin
        if (wcnt >= ack_dly) begin
          imem_ack   = 1'b1;
          imem_rdata = imem[imem_addr];
          wcnt       = 0;
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end
    end
  end

  // Monitor of accepted fetches and execute strobes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req && imem_ack) fetch_log.push_back(imem_addr);
      if (exec_en) begin
        exec_cnt++;
        exec_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) imem[i] = 8'h11;
  endtask

  task automatic hold_reset();
    rst_n   = 1'b0;
    ack_dly = 0;
    repeat (2) @(negedge clk);
    fetch_log.delete();
    exec_cyc.delete();
    exec_cnt = 0;
  endtask

  // Waits for n more execute strobes, returning in the last EXEC cycle.
  task automatic wait_exec(input int n, input string tag);
    int start;
    int k;
    start = exec_cnt;
    k     = 0;
    while (exec_cnt < start + n && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(tag, exec_cnt - start, n);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    cyc     = 0;
    exec_cnt = 0;
    ack_dly = 0;
    rst_n   = 1'b0;

    // 1: reset values, back-to-back 1-byte instructions
    fill_nop();
    imem[0] = 8'h05;
    imem[1] = 8'h11;
    hold_reset();
    #1;
    check("rst_pc", pc, 8'h00);
    check("rst_ir", ir, 8'h11);
    check("rst_arg", arg, 8'h00);
    check("rst_req", imem_req, 1'b0);
    check("rst_exec", exec_en, 1'b0);
    check("rst_flags", stack_flags, 2'b01);
    check("rst_err", stack_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("t1_req_rise", imem_req, 1'b1);
    check("t1_addr0", imem_addr, 8'h00);
    wait_exec(1, "t1_exec1");
    check("t1_ir", ir, 8'h05);
    wait_exec(1, "t1_exec2");
    check("t1_pc", pc, 8'h02);
    check("t1_exec_gap", exec_cyc[1] - exec_cyc[0], 2);
    check("t1_fetch1", fetch_log[1], 8'h01);

    // 2: JMP 0x40
    hold_reset();
    imem[0] = 8'h40;
    imem[1] = 8'h40;
    @(negedge clk);
    rst_n = 1'b1;
    wait_exec(1, "t2_exec");
    after_edge();
    check("t2_pc", pc, 8'h40);
    check("t2_execs", exec_cnt, 1);
    repeat (3) @(negedge clk);
    #1;
    check("t2_fetch2", fetch_log[2], 8'h40);
    check("t2_flags", stack_flags, 2'b01);

    // 3: CLL 0x20 at 0x10, RET at 0x20
    hold_reset();
    fill_nop();
    imem[0]    = 8'h40;
    imem[1]    = 8'h10;
    imem[8'h10] = 8'h50;
    imem[8'h11] = 8'h20;
    imem[8'h20] = 8'h60;
    @(negedge clk);
    rst_n = 1'b1;
    wait_exec(2, "t3_call");
    after_edge();
    check("t3_call_pc", pc, 8'h20);
    check("t3_call_flags", stack_flags, 2'b00);
    wait_exec(1, "t3_ret");
    after_edge();
    check("t3_ret_pc", pc, 8'h12);
    check("t3_ret_flags", stack_flags, 2'b01);
    repeat (3) @(negedge clk);
    #1;
    check("t3_fetch_ret", fetch_log[5], 8'h12);

    // 4: nested calls to FULL, then a forced extra push
    hold_reset();
    fill_nop();
    for (int k = 0; k <= 8; k++) begin
      imem[k*16]   = 8'h50;
      imem[k*16+1] = 8'((k + 1) * 16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_exec(8, "t4_calls");
    after_edge();
    check("t4_full", stack_flags, 2'b10);
    check("t4_err_pre", stack_err, 1'b0);
    wait_exec(1, "t4_over");
    after_edge();
    check("t4_err", stack_err, 1'b1);
    check("t4_flags_kept", stack_flags, 2'b10);
    check("t4_pc", pc, 8'h82);
`ifdef PC_SEQ_STACK_TRAP_EN
    repeat (4) @(negedge clk);
    #1;
    check("t4_halt_req", imem_req, 1'b0);
`else
    wait_exec(1, "t4_continue");
`endif

    // 5: RET on empty stack with slow memory
    hold_reset();
    fill_nop();
    imem[0] = 8'h60;
    ack_dly = 3;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t5_wait_ack", imem_ack, 1'b0);
      check("t5_addr_hold", imem_addr, 8'h00);
      @(negedge clk);
    end
    wait_exec(1, "t5_exec");
    after_edge();
    check("t5_err", stack_err, 1'b1);
    check("t5_pc", pc, 8'h01);
    check("t5_flags", stack_flags, 2'b01);
`ifndef PC_SEQ_STACK_TRAP_EN
    @(negedge clk);
    #1;
    check("t5_next_addr", imem_addr, 8'h01);
`endif

    // 6: async reset mid-ARG at depth 3, then soft reset in EXEC
    hold_reset();
    fill_nop();
    for (int k = 0; k <= 8; k++) begin
      imem[k*16]   = 8'h50;
      imem[k*16+1] = 8'((k + 1) * 16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_exec(3, "t6_calls");
    after_edge();
    check("t6_depth3_flags", stack_flags, 2'b00);
    ack_dly = 3;
    begin
      int k;
      k = 0;
      while (!(imem_req && imem_addr == 8'h31) && k < 40) begin
        @(negedge clk);
        #1;
        k++;
      end
      check("t6_reach_arg", imem_addr, 8'h31);
    end
    rst_n = 1'b0;
    #1;
    check("t6_pc", pc, 8'h00);
    check("t6_flags", stack_flags, 2'b01);
    check("t6_ir", ir, 8'h11);
    check("t6_req", imem_req, 1'b0);
    hold_reset();
    fill_nop();
    imem[0]     = 8'h50;
    imem[1]     = 8'h30;
    imem[8'h30] = 8'h7F;
    @(negedge clk);
    rst_n = 1'b1;
    wait_exec(1, "t6_call");
    after_edge();
    check("t6_call_flags", stack_flags, 2'b00);
    wait_exec(1, "t6_softrst");
    after_edge();
    check("t6_srst_pc", pc, 8'h00);
    check("t6_srst_ir", ir, 8'h11);
    check("t6_srst_flags", stack_flags, 2'b01);
    check("t6_srst_err", stack_err, 1'b0);

    // 7: illegal stack_control
    hold_reset();
    fill_nop();
    imem[0] = 8'h33;
    @(negedge clk);
    rst_n = 1'b1;
    wait_exec(1, "t7_exec");
    after_edge();
    check("t7_err", stack_err, 1'b1);
    check("t7_pc", pc, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
